switch_debounce: RTL and testbench

//  Input-side counterpart to the LED stretcher path. Takes a raw, bouncy,

---
 rtl/switch_debounce.sv | 146 ++++++++++++++
 tb/tb_switch_debounce.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// switch_debounce
//   Brings a raw, bouncy mechanical switch into the i_clk domain. It produces
//   a clean debounced level, one-cycle press and release strobes, and a
//   saturating count of rejected transitions.
//
//   Ports
//     i_clk         system clock
//     i_reset       asynchronous, active-high reset
//     i_sw          raw switch input; asynchronous to i_clk and may bounce
//     o_level       debounced switch level (registered)
//     o_press       one-cycle strobe on a debounced 0->1 change (registered)
//     o_release     one-cycle strobe on a debounced 1->0 change (registered)
//     o_glitch_cnt  count of aborted transitions; saturates at 255
//
//   A new value must be seen on STABLE+1 consecutive synchronised samples
//   before it is accepted: one sample to enter the transition state, then
//   STABLE samples to confirm it. A contrary sample aborts the attempt and
//   counts as a glitch.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   S_LOW  | debounced level is 0; waiting for a 1 sample
//   S_RISE | candidate 0->1 change; counting consecutive 1 samples
//   S_HIGH | debounced level is 1; waiting for a 0 sample
//   S_FALL | candidate 1->0 change; counting consecutive 0 samples

module switch_debounce #(
  parameter int STABLE = 1000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_sw,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic [7:0] o_glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  logic             ff1;
  logic             s;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             release_nxt;
  logic             glitch_hit;

  // Two-flop synchroniser; only s is seen by the state machine.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ff1 <= 1'b0;
      s   <= 1'b0;
    end else begin
      ff1 <= i_sw;
      s   <= ff1;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = o_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    glitch_hit  = 1'b0;
    case (state)
      S_LOW: begin
        if (s) begin
          state_nxt = S_RISE;
          cnt_nxt   = ONE_C;
        end
      end
      S_RISE: begin
        if (!s) begin
          state_nxt  = S_LOW;
          cnt_nxt    = '0;
          glitch_hit = 1'b1;
        end else if (cnt == STABLE_C) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE_C;
        end
      end
      S_HIGH: begin
        if (!s) begin
          state_nxt = S_FALL;
          cnt_nxt   = ONE_C;
        end
      end
      S_FALL: begin
        if (s) begin
          state_nxt  = S_HIGH;
          cnt_nxt    = '0;
          glitch_hit = 1'b1;
        end else if (cnt == STABLE_C) begin
          state_nxt   = S_LOW;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE_C;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= S_LOW;
      cnt          <= '0;
      o_level      <= 1'b0;
      o_press      <= 1'b0;
      o_release    <= 1'b0;
      o_glitch_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_level   <= level_nxt;
      o_press   <= press_nxt;
      o_release <= release_nxt;
      // Saturate: a glitch seen at 255 is dropped.
      if (glitch_hit && (o_glitch_cnt != 8'hFF))
        o_glitch_cnt <= o_glitch_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
module tb_switch_debounce;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic       level;
  logic       press;
  logic       rel;
  logic [7:0] gcnt;

  switch_debounce #(.STABLE(STABLE)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sw        (sw),
    .o_level     (level),
    .o_press     (press),
    .o_release   (rel),
    .o_glitch_cnt(gcnt)
  );

  always #5 clk = ~clk;

  // Reference model: a value is accepted after STABLE+1 consecutive contrary
  // samples of the synchronised input; a shorter contrary run that ends is
  // a glitch. The synchroniser is modelled as a two-deep delay queue.
  bit dq[$];
  int run;
  int m_lvl, m_press, m_rel, m_gc;
  int tests = 0;
  int fails = 0;
  int edge_at;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dq = '{1'b0, 1'b0};
    run = 0; m_lvl = 0; m_press = 0; m_rel = 0; m_gc = 0;
  endtask

  task automatic model_edge(input bit v);
    bit smp;
    smp = dq.pop_front();
    dq.push_back(v);
    m_press = 0;
    m_rel = 0;
    if (int'(smp) != m_lvl) begin
      run++;
      if (run == STABLE + 1) begin
        m_lvl = int'(smp);
        run = 0;
        if (smp) m_press = 1; else m_rel = 1;
      end
    end else begin
      if (run > 0 && m_gc < 255) m_gc++;
      run = 0;
    end
  endtask

  task automatic check_all();
    chk("level", 32'(level), 32'(m_lvl));
    chk("press", 32'(press), 32'(m_press));
    chk("release", 32'(rel), 32'(m_rel));
    chk("glitch_cnt", 32'(gcnt), 32'(m_gc));
    chk("strobe_excl", 32'(press & rel), 32'd0);
  endtask

  task automatic step(input bit v);
    sw = v;
    @(posedge clk);
    if (rst) model_reset(); else model_edge(v);
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    sw  = 1'b0;
    model_reset();
    repeat (3) step(1'b0);
    rst = 1'b0;

    // 1: idle low
    repeat (20) step(1'b0);
    chk("t1_level", 32'(level), 32'd0);
    chk("t1_gcnt", 32'(gcnt), 32'd0);

    // 3: short 3-cycle pulse is rejected
    repeat (3) step(1'b1);
    repeat (8) step(1'b0);
    chk("t3_level", 32'(level), 32'd0);
    chk("t3_gcnt", 32'(gcnt), 32'd1);

    // 2: held high; press on the 7th edge counting the first sampling edge as 1
    edge_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (press === 1'b1 && edge_at == 0) edge_at = i;
    end
    chk("t2_press_edge", 32'(edge_at), 32'd7);
    chk("t2_level", 32'(level), 32'd1);

    // 4: bounce 0/1/0/1 then hold 0
    step(1'b0); step(1'b1); step(1'b0); step(1'b1);
    edge_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      if (rel === 1'b1 && edge_at == 0) edge_at = i;
    end
    chk("t4_release_edge", 32'(edge_at), 32'd7);
    chk("t4_gcnt", 32'(gcnt), 32'd3);
    chk("t4_level", 32'(level), 32'd0);

    // 5: reset while rising with cnt=3
    repeat (5) step(1'b1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("t5_async_level", 32'(level), 32'd0);
    chk("t5_async_press", 32'(press), 32'd0);
    chk("t5_async_gcnt", 32'(gcnt), 32'd0);
    step(1'b1);
    rst = 1'b0;
    edge_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (press === 1'b1 && edge_at == 0) edge_at = i;
    end
    chk("t5_press_edge", 32'(edge_at), 32'd7);

    // 6: saturate the glitch counter, then debounce again
    repeat (10) step(1'b0);
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      step(1'b0);
    end
    repeat (4) step(1'b0);
    chk("t6_gcnt_sat", 32'(gcnt), 32'd255);
    edge_at = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (press === 1'b1 && edge_at == 0) edge_at = i;
    end
    chk("t6_press_edge", 32'(edge_at), 32'd7);
    chk("t6_gcnt_hold", 32'(gcnt), 32'd255);

    // Random runs, including an occasional reset
    for (int r = 0; r < 80; r++) begin
      bit v;
      int len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        step(v);
        rst = 1'b0;
      end
      repeat (len) step(v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
